// File: rtl/jtcps1_obj_pkg.sv
// Shared definitions for the CPS1 object-ROM arbiter: ROM geometry and the
// arbiter FSM state encoding.
package jtcps1_obj_pkg;

  localparam int OBJ_ROM_AW = 20;
  localparam int OBJ_ROM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/jtcps1_obj_arb_slot.sv
// One requester's result cache: tag/valid/data of the last completed fill and
// the combinational hit compare that drives the engine's ok flag.
module jtcps1_obj_arb_slot
  import jtcps1_obj_pkg::*;
#(
  parameter int AW = OBJ_ROM_AW,
  parameter int DW = OBJ_ROM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] req_addr,
  input  logic          req_half,
  input  logic          req_cs,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic          fill_half,
  input  logic [DW-1:0] fill_data,
  output logic [DW-1:0] data,
  output logic          ok,
  output logic          pend
);

  logic [AW-1:0] tag_addr;
  logic          tag_half;
  logic          valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_addr <= '0;
      tag_half <= 1'b0;
      valid    <= 1'b0;
      data     <= '0;
    end else if (fill) begin
      tag_addr <= fill_addr;
      tag_half <= fill_half;
      valid    <= 1'b1;
      data     <= fill_data;
    end
  end

  // A hit needs the engine to be asking right now, so ok is low whenever cs is.
  assign ok   = valid & req_cs & (req_addr == tag_addr) & (req_half == tag_half);
  assign pend = req_cs & ~ok;

endmodule

// File: rtl/jtcps1_obj_rom_arb.sv
// Shares the object-ROM SDRAM slot between two draw engines with per-engine
// result caching. Define JTCPS1_OBJ_ARB_FIXPRI_EN for fixed engine-0 priority.
module jtcps1_obj_rom_arb
  import jtcps1_obj_pkg::*;
#(
  parameter int AW = OBJ_ROM_AW,
  parameter int DW = OBJ_ROM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] req0_addr,
  input  logic          req0_half,
  input  logic          req0_cs,
  output logic [DW-1:0] req0_data,
  output logic          req0_ok,
  input  logic [AW-1:0] req1_addr,
  input  logic          req1_half,
  input  logic          req1_cs,
  output logic [DW-1:0] req1_data,
  output logic          req1_ok,
  output logic [AW-1:0] rom_addr,
  output logic          rom_half,
  output logic          rom_cs,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  arb_state_e    state, state_nxt;
  logic          grant, grant_nxt;
  logic          last_grant, last_grant_nxt;
  logic          rom_cs_nxt;
  logic [AW-1:0] rom_addr_nxt;
  logic          rom_half_nxt;
  logic          pend0, pend1;
  logic          fill0, fill1;
  logic          pick;
  logic          g_cs, g_half, abort;
  logic [AW-1:0] g_addr;

  jtcps1_obj_arb_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_addr  (req0_addr),
    .req_half  (req0_half),
    .req_cs    (req0_cs),
    .fill      (fill0),
    .fill_addr (rom_addr),
    .fill_half (rom_half),
    .fill_data (rom_data),
    .data      (req0_data),
    .ok        (req0_ok),
    .pend      (pend0)
  );

  jtcps1_obj_arb_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_addr  (req1_addr),
    .req_half  (req1_half),
    .req_cs    (req1_cs),
    .fill      (fill1),
    .fill_addr (rom_addr),
    .fill_half (rom_half),
    .fill_data (rom_data),
    .data      (req1_data),
    .ok        (req1_ok),
    .pend      (pend1)
  );

  // The granted engine must still want exactly what is on the ROM bus,
  // otherwise the transfer is abandoned without filling its cache.
  assign g_cs   = grant ? req1_cs   : req0_cs;
  assign g_addr = grant ? req1_addr : req0_addr;
  assign g_half = grant ? req1_half : req0_half;
  assign abort  = ~g_cs | (g_addr != rom_addr) | (g_half != rom_half);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      rom_half   <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      rom_cs     <= rom_cs_nxt;
      rom_addr   <= rom_addr_nxt;
      rom_half   <= rom_half_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    rom_cs_nxt     = rom_cs;
    rom_addr_nxt   = rom_addr;
    rom_half_nxt   = rom_half;
    fill0          = 1'b0;
    fill1          = 1'b0;
`ifdef JTCPS1_OBJ_ARB_FIXPRI_EN
    pick           = ~pend0;
`else
    pick           = (pend0 & pend1) ? ~last_grant : pend1;
`endif
    case (state)
      ST_IDLE: begin
        if (pend0 | pend1) begin
          grant_nxt      = pick;
          last_grant_nxt = pick;
          rom_addr_nxt   = pick ? req1_addr : req0_addr;
          rom_half_nxt   = pick ? req1_half : req0_half;
          rom_cs_nxt     = 1'b1;
          state_nxt      = ST_ISSUE;
        end
      end
      // rom_ok here may still belong to the previous access, so it is ignored.
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (abort) begin
          rom_cs_nxt = 1'b0;
          state_nxt  = ST_GAP;
        end else if (rom_ok) begin
          fill0      = ~grant;
          fill1      = grant;
          rom_cs_nxt = 1'b0;
          state_nxt  = ST_GAP;
        end
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtcps1_obj_rom_arb.sv
// Directed, table-driven bench for jtcps1_obj_rom_arb: one vector per clock
// cycle, inputs applied after the rising edge and outputs checked on the falling edge.
module tb_jtcps1_obj_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] req0_addr = '0, req1_addr = '0, rom_addr;
  logic        req0_half = 1'b0, req0_cs = 1'b0, req1_half = 1'b0, req1_cs = 1'b0;
  logic [31:0] req0_data, req1_data, rom_data = '0;
  logic        req0_ok, req1_ok, rom_half, rom_cs;
  logic        rom_ok = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        rst_n;
    logic [19:0] a0;
    logic        h0;
    logic        c0;
    logic [19:0] a1;
    logic        h1;
    logic        c1;
    logic        rok;
    logic [31:0] rdat;
    logic        e_cs;
    logic [19:0] e_addr;
    logic        e_half;
    logic        e_ok0;
    logic [31:0] e_d0;
    logic        e_ok1;
    logic [31:0] e_d1;
  } vec_t;

  jtcps1_obj_rom_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_addr (req0_addr),
    .req0_half (req0_half),
    .req0_cs   (req0_cs),
    .req0_data (req0_data),
    .req0_ok   (req0_ok),
    .req1_addr (req1_addr),
    .req1_half (req1_half),
    .req1_cs   (req1_cs),
    .req1_data (req1_data),
    .req1_ok   (req1_ok),
    .rom_addr  (rom_addr),
    .rom_half  (rom_half),
    .rom_cs    (rom_cs),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [19:0] a0, input logic h0, input logic c0,
                              input logic [19:0] a1, input logic h1, input logic c1,
                              input logic rok, input logic [31:0] rdat,
                              input logic ecs, input logic [19:0] eaddr, input logic ehalf,
                              input logic eok0, input logic [31:0] ed0,
                              input logic eok1, input logic [31:0] ed1);
    vec_t v;
    v.rst_n = rst; v.a0 = a0; v.h0 = h0; v.c0 = c0;
    v.a1 = a1; v.h1 = h1; v.c1 = c1; v.rok = rok; v.rdat = rdat;
    v.e_cs = ecs; v.e_addr = eaddr; v.e_half = ehalf;
    v.e_ok0 = eok0; v.e_d0 = ed0; v.e_ok1 = eok1; v.e_d1 = ed1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    rst_n = v.rst_n;
    req0_addr = v.a0; req0_half = v.h0; req0_cs = v.c0;
    req1_addr = v.a1; req1_half = v.h1; req1_cs = v.c1;
    rom_ok = v.rok; rom_data = v.rdat;
    @(negedge clk);
    chk($sformatf("%s.rom_cs", tag), {31'd0, rom_cs}, {31'd0, v.e_cs});
    if (v.e_cs || !v.rst_n) begin
      chk($sformatf("%s.rom_addr", tag), {12'd0, rom_addr}, {12'd0, v.e_addr});
      chk($sformatf("%s.rom_half", tag), {31'd0, rom_half}, {31'd0, v.e_half});
    end
    chk($sformatf("%s.req0_ok", tag), {31'd0, req0_ok}, {31'd0, v.e_ok0});
    if (v.e_ok0 || !v.rst_n) chk($sformatf("%s.req0_data", tag), req0_data, v.e_d0);
    chk($sformatf("%s.req1_ok", tag), {31'd0, req1_ok}, {31'd0, v.e_ok1});
    if (v.e_ok1 || !v.rst_n) chk($sformatf("%s.req1_data", tag), req1_data, v.e_d1);
  endtask

  initial begin
    vec_t tbl[$];
    logic fp;
    logic [19:0] f_addr, s_addr;
    logic [31:0] d0x;
`ifdef JTCPS1_OBJ_ARB_FIXPRI_EN
    fp = 1'b1;
`else
    fp = 1'b0;
`endif
    f_addr = fp ? 20'h00500 : 20'h00600;
    s_addr = fp ? 20'h00600 : 20'h00500;
    d0x    = fp ? 32'hD3D3D3D3 : 32'hE4E4E4E4;

    // single fill, cache hit, stale ok on a half flip, reset, tie from reset
    tbl.push_back(mk(1, 'h12345,0,1, 0,0,0, 0,0,           0,0,0,        0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,0,1, 0,0,0, 0,0,           1,'h12345,0,  0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,0,1, 0,0,0, 0,0,           1,'h12345,0,  0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,0,1, 0,0,0, 0,0,           1,'h12345,0,  0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,0,1, 0,0,0, 1,'hDEADBEEF,  1,'h12345,0,  0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,0,1, 0,0,0, 0,0,           0,0,0,        1,'hDEADBEEF,   0,0));
    tbl.push_back(mk(1, 'h12345,0,1, 0,0,0, 0,0,           0,0,0,        1,'hDEADBEEF,   0,0));
    tbl.push_back(mk(1, 'h12345,1,1, 0,0,0, 1,'h11111111,  0,0,0,        0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,1,1, 0,0,0, 1,'h22222222,  1,'h12345,1,  0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,1,1, 0,0,0, 1,'h33333333,  1,'h12345,1,  0,0,            0,0));
    tbl.push_back(mk(1, 'h12345,1,1, 0,0,0, 0,0,           0,0,0,        1,'h33333333,   0,0));
    tbl.push_back(mk(1, 'h12345,1,0, 0,0,0, 0,0,           0,0,0,        0,0,            0,0));
    tbl.push_back(mk(0, 0,0,0,       0,0,0, 0,0,           0,0,0,        0,0,            0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 0,0,           0,0,0,       0,0,          0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 0,0,           1,'h00100,0, 0,0,          0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 1,'hA0A0A0A0,  1,'h00100,0, 0,0,          0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 0,0,           0,0,0,       1,'hA0A0A0A0, 0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 0,0,           0,0,0,       1,'hA0A0A0A0, 0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 0,0,           1,'h00200,0, 1,'hA0A0A0A0, 0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 1,'hB1B1B1B1,  1,'h00200,0, 1,'hA0A0A0A0, 0,0));
    tbl.push_back(mk(1, 'h00100,0,1, 'h00200,0,1, 0,0,           0,0,0,       1,'hA0A0A0A0, 1,'hB1B1B1B1));

    repeat (3) @(posedge clk);
    #1;
    chk("reset.rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("reset.req0_ok", {31'd0, req0_ok}, 32'd0);
    chk("reset.req1_data", req1_data, 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("t%0d", i));

    // Engine 0 alone, then a tie: round-robin now favours engine 1
    run_vec(mk(1, 'h00300,0,1, 'h00200,0,1, 0,0,          0,0,0,       0,0,          1,'hB1B1B1B1), "rr0");
    run_vec(mk(1, 'h00300,0,1, 'h00200,0,1, 0,0,          1,'h00300,0, 0,0,          1,'hB1B1B1B1), "rr1");
    run_vec(mk(1, 'h00300,0,1, 'h00200,0,1, 1,'hC2C2C2C2, 1,'h00300,0, 0,0,          1,'hB1B1B1B1), "rr2");
    run_vec(mk(1, 'h00300,0,1, 'h00200,0,1, 0,0,          0,0,0,       1,'hC2C2C2C2, 1,'hB1B1B1B1), "rr3");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 0,0,          0,0,0,       0,0,          0,0), "rr4");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 0,0,          1,f_addr,0,  0,0,          0,0), "rr5");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 1,'hD3D3D3D3, 1,f_addr,0,  0,0,          0,0), "rr6");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 0,0,          0,0,0,       fp,'hD3D3D3D3, ~fp,'hD3D3D3D3), "rr7");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 0,0,          0,0,0,       fp,'hD3D3D3D3, ~fp,'hD3D3D3D3), "rr8");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 0,0,          1,s_addr,0,  fp,'hD3D3D3D3, ~fp,'hD3D3D3D3), "rr9");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 1,'hE4E4E4E4, 1,s_addr,0,  fp,'hD3D3D3D3, ~fp,'hD3D3D3D3), "rr10");
    run_vec(mk(1, 'h00500,0,1, 'h00600,0,1, 0,0,          0,0,0,       1,d0x,         1,(fp ? 32'hE4E4E4E4 : 32'hD3D3D3D3)), "rr11");

    // Abort in WAIT with a same-cycle rom_ok, then the retry for the new address
    run_vec(mk(1, 0,0,0, 'h00010,0,1, 0,0,          0,0,0,       0,0, 0,0), "ab0");
    run_vec(mk(1, 0,0,0, 'h00010,0,1, 0,0,          1,'h00010,0, 0,0, 0,0), "ab1");
    run_vec(mk(1, 0,0,0, 'h00010,0,1, 0,0,          1,'h00010,0, 0,0, 0,0), "ab2");
    run_vec(mk(1, 0,0,0, 'h00020,0,1, 1,'hF5F5F5F5, 1,'h00010,0, 0,0, 0,0), "ab3");
    run_vec(mk(1, 0,0,0, 'h00010,0,1, 0,0,          0,0,0,       0,0, 0,0), "ab4");
    run_vec(mk(1, 0,0,0, 'h00020,0,1, 0,0,          0,0,0,       0,0, 0,0), "ab5");
    run_vec(mk(1, 0,0,0, 'h00020,0,1, 0,0,          1,'h00020,0, 0,0, 0,0), "ab6");
    run_vec(mk(1, 0,0,0, 'h00020,0,1, 1,'h0F0F0F0F, 1,'h00020,0, 0,0, 0,0), "ab7");
    run_vec(mk(1, 0,0,0, 'h00020,0,1, 0,0,          0,0,0,       0,0, 1,'h0F0F0F0F), "ab8");

    // Asynchronous reset during WAIT, then a late rom_ok after release
    run_vec(mk(1, 'h00500,0,1, 'h00030,0,1, 0,0, 0,0,0,       1,d0x, 0,0), "rs0");
    run_vec(mk(1, 'h00500,0,1, 'h00030,0,1, 0,0, 1,'h00030,0, 1,d0x, 0,0), "rs1");
    run_vec(mk(1, 'h00500,0,1, 'h00030,0,1, 0,0, 1,'h00030,0, 1,d0x, 0,0), "rs2");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("async.rom_cs", {31'd0, rom_cs}, 32'd0);
    chk("async.rom_addr", {12'd0, rom_addr}, 32'd0);
    chk("async.req0_ok", {31'd0, req0_ok}, 32'd0);
    chk("async.req0_data", req0_data, 32'd0);
    chk("async.req1_ok", {31'd0, req1_ok}, 32'd0);
    run_vec(mk(1, 0,0,0, 0,0,0,          1,'h12121212, 0,0,0,       0,0, 0,0), "rs3");
    run_vec(mk(1, 0,0,0, 'h00030,0,1,    0,0,          0,0,0,       0,0, 0,0), "rs4");
    run_vec(mk(1, 0,0,0, 'h00030,0,1,    0,0,          1,'h00030,0, 0,0, 0,0), "rs5");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
